// File: rtl/ldtu_bsl_pkg.sv
// Shared types and constants for the LiTe-DTU baseline subtraction / tracking block.
package ldtu_bsl_pkg;

  // Per-channel auto-baseline state
  typedef enum logic [1:0] {
    INIT   = 2'd0,
    TRACK  = 2'd1,
    UPDATE = 2'd2
  } bsl_state_e;

  // Per-channel baseline source selection
  localparam logic BSL_FIXED = 1'b0;
  localparam logic BSL_AUTO  = 1'b1;

  // Default geometry
  localparam int NCH_DEF      = 2;
  localparam int DW_DEF       = 12;
  localparam int BW_DEF       = 8;
  localparam int LOG2_WIN_DEF = 4;

endpackage

// File: rtl/ldtu_bsl_chan.sv
// One channel: input shift (S1), baseline subtraction with zero clamp (S2),
// and the auto-baseline accumulator / window counter / FSM.
//
// state  | meaning
// -------+--------------------------------------------------------------
// INIT   | first window after reset or fixed->auto: every sample accepted
// TRACK  | only samples at or below bsl_cur + auto_thr are accepted
// UPDATE | one cycle: load averaged window into bsl_cur, restart window
module ldtu_bsl_chan
  import ldtu_bsl_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int BW       = BW_DEF,
  parameter int LOG2_WIN = LOG2_WIN_DEF
) (
  input  logic          CLK,
  input  logic          rst_b,
  input  logic          in_valid,
  input  logic          v1,
  input  logic [DW-1:0] sample,
  input  logic [1:0]    shift,
  input  logic          mode,
  input  logic [BW-1:0] bsl_val,
  input  logic [DW-1:0] auto_thr,
  input  logic          freeze,
  output logic [DW-1:0] data_out,
  output logic [BW-1:0] bsl_cur,
  output logic          uf_evt
);

  localparam int AW = DW + LOG2_WIN;
  localparam logic [LOG2_WIN:0] CNT_FULL = {1'b1, {LOG2_WIN{1'b0}}};
  localparam logic [LOG2_WIN:0] CNT_ONE  = {{LOG2_WIN{1'b0}}, 1'b1};

  bsl_state_e        state;
  logic [DW-1:0]     d1;
  logic [AW-1:0]     acc;
  logic [LOG2_WIN:0] cnt;

  logic [DW:0]       d1_ext;
  logic [DW:0]       bsl_ext;
  logic [DW:0]       diff;
  logic [DW:0]       thr_lim;
  logic              below_thr;
  logic              accept;
  logic [AW-1:0]     acc_nxt;
  logic [LOG2_WIN:0] cnt_nxt;
  logic [DW-1:0]     avg;
  logic [BW-1:0]     bsl_sat;

  // Subtraction and acceptance compare are both done one bit wider so the sign /
  // carry is never lost.
  assign d1_ext    = {1'b0, d1};
  assign bsl_ext   = {{(DW + 1 - BW){1'b0}}, bsl_cur};
  assign diff      = d1_ext - bsl_ext;
  assign thr_lim   = bsl_ext + {1'b0, auto_thr};
  assign below_thr = (d1_ext <= thr_lim);
  assign uf_evt    = v1 & diff[DW];

  assign accept  = v1 & ~freeze & ((state == INIT) | ((state == TRACK) & below_thr));
  assign acc_nxt = acc + {{LOG2_WIN{1'b0}}, d1};
  assign cnt_nxt = cnt + CNT_ONE;
  assign avg     = acc[AW-1:LOG2_WIN];

  // Window average saturates into the narrower baseline register.
  if (BW < DW) begin : g_sat
    assign bsl_sat = (|avg[DW-1:BW]) ? {BW{1'b1}} : avg[BW-1:0];
  end else begin : g_nosat
    assign bsl_sat = avg;
  end

  // S1: capture the shifted sample.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      d1 <= '0;
    end else if (in_valid) begin
      d1 <= sample >> shift;
    end
  end

  // S2: baseline subtraction, clamped at zero; holds while no sample.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      data_out <= '0;
    end else if (v1) begin
      data_out <= diff[DW] ? '0 : diff[DW-1:0];
    end
  end

  // Baseline selection and auto-tracking FSM.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state   <= INIT;
      acc     <= '0;
      cnt     <= '0;
      bsl_cur <= '0;
    end else if (mode == BSL_FIXED) begin
      state   <= INIT;
      acc     <= '0;
      cnt     <= '0;
      bsl_cur <= bsl_val;
    end else begin
      case (state)
        INIT, TRACK: begin
          if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (cnt_nxt == CNT_FULL) begin
              state <= UPDATE;
            end
          end
        end
        UPDATE: begin
          bsl_cur <= bsl_sat;
          acc     <= '0;
          cnt     <= '0;
          state   <= TRACK;
        end
        default: begin
          state <= INIT;
          acc   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ldtu_bsl_tracker.sv
// Multi-channel baseline subtraction with optional auto baseline tracking.
// The top owns the shared valid pipeline and the sticky underflow flags;
// everything per channel lives in ldtu_bsl_chan.
module ldtu_bsl_tracker
  import ldtu_bsl_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int DW       = DW_DEF,
  parameter int BW       = BW_DEF,
  parameter int LOG2_WIN = LOG2_WIN_DEF
) (
  input  logic              CLK,
  input  logic              rst_b,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH*2-1:0]  shift,
  input  logic [NCH-1:0]    bsl_mode,
  input  logic [NCH*BW-1:0] bsl_val,
  input  logic [DW-1:0]     auto_thr,
  input  logic              freeze,
  input  logic              clr_flags,
  output logic              out_valid,
  output logic [NCH*DW-1:0] data_out,
  output logic [NCH*BW-1:0] bsl_cur,
  output logic [NCH-1:0]    underflow
);

  logic           v1;
  logic [NCH-1:0] uf_evt;

  // Shared two-stage valid pipeline.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
    end
  end

  // Sticky underflow flags; a clear in the same cycle as a set wins.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      underflow <= '0;
    end else if (clr_flags) begin
      underflow <= '0;
    end else begin
      underflow <= underflow | uf_evt;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    ldtu_bsl_chan #(
      .DW       (DW),
      .BW       (BW),
      .LOG2_WIN (LOG2_WIN)
    ) u_chan (
      .CLK      (CLK),
      .rst_b    (rst_b),
      .in_valid (in_valid),
      .v1       (v1),
      .sample   (data_in[c*DW +: DW]),
      .shift    (shift[c*2 +: 2]),
      .mode     (bsl_mode[c]),
      .bsl_val  (bsl_val[c*BW +: BW]),
      .auto_thr (auto_thr),
      .freeze   (freeze),
      .data_out (data_out[c*DW +: DW]),
      .bsl_cur  (bsl_cur[c*BW +: BW]),
      .uf_evt   (uf_evt[c])
    );
  end

endmodule

// File: tb/tb_ldtu_bsl_tracker.sv
// Directed bench for ldtu_bsl_tracker with the default geometry
// (2 channels, 12-bit samples, 8-bit baselines, 16-sample window).
module tb_ldtu_bsl_tracker;

  logic        CLK;
  logic        rst_b;
  logic        in_valid;
  logic [23:0] data_in;
  logic [3:0]  shift;
  logic [1:0]  bsl_mode;
  logic [15:0] bsl_val;
  logic [11:0] auto_thr;
  logic        freeze;
  logic        clr_flags;
  logic        out_valid;
  logic [23:0] data_out;
  logic [15:0] bsl_cur;
  logic [1:0]  underflow;

  int total = 0;
  int bad   = 0;

  ldtu_bsl_tracker dut (
    .CLK       (CLK),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .shift     (shift),
    .bsl_mode  (bsl_mode),
    .bsl_val   (bsl_val),
    .auto_thr  (auto_thr),
    .freeze    (freeze),
    .clr_flags (clr_flags),
    .out_valid (out_valid),
    .data_out  (data_out),
    .bsl_cur   (bsl_cur),
    .underflow (underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [11:0] d_ch1, input logic [11:0] d_ch0);
    data_in  = {d_ch1, d_ch0};
    in_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst_b     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    shift     = '0;
    bsl_mode  = '0;
    bsl_val   = '0;
    auto_thr  = '0;
    freeze    = 1'b0;
    clr_flags = 1'b0;

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_bsl_cur", bsl_cur, 0);
    chk("rst_underflow", underflow, 0);
    tick();
    rst_b = 1'b1;

    // fixed baseline, underflow on ch0
    bsl_val = {8'd50, 8'd100};
    tick();
    send(12'd1000, 12'd80);
    chk("fix_lat_k1", out_valid, 0);
    idle(1);
    chk("fix_out_valid", out_valid, 1);
    chk("fix_data", data_out, {12'd950, 12'd0});
    chk("fix_underflow", underflow, 2'b01);
    idle(1);
    chk("fix_ov_drop", out_valid, 0);
    chk("fix_hold", data_out, {12'd950, 12'd0});

    // shift and bsl_val change timing
    bsl_val = {8'd23, 8'd23};
    shift   = {2'd2, 2'd2};
    chk("bslval_before_edge", bsl_cur, {8'd50, 8'd100});
    idle(1);
    chk("bslval_after_edge", bsl_cur, {8'd23, 8'd23});
    send(12'd4095, 12'd4095);
    idle(1);
    chk("shift_data", data_out, {12'd1000, 12'd1000});

    // auto INIT on ch0, ch1 fixed at 10
    shift    = '0;
    bsl_mode = 2'b01;
    bsl_val  = {8'd10, 8'd23};
    auto_thr = 12'd20;
    for (int i = 1; i <= 16; i++) begin
      send(12'd500, 12'd200);
      if (i == 2) chk("init_first_data", data_out, {12'd490, 12'd177});
    end
    idle(1);
    chk("init_pre_update", bsl_cur[7:0], 23);
    idle(1);
    chk("init_update", bsl_cur, {8'd10, 8'd200});
    send(12'd500, 12'd260);
    idle(1);
    chk("init_s17", data_out, {12'd490, 12'd60});

    // TRACK rejection: alternate 210 / 3000
    for (int i = 1; i <= 32; i++) begin
      send(12'd500, (i % 2 == 1) ? 12'd210 : 12'd3000);
      if (i == 2)  chk("trk_acc_out", data_out[11:0], 10);
      if (i == 3)  chk("trk_rej_out_old", data_out[11:0], 2800);
      if (i == 32) chk("trk_pre_update", bsl_cur[7:0], 200);
    end
    idle(1);
    chk("trk_update_cycle_out", data_out[11:0], 2800);
    chk("trk_update", bsl_cur[7:0], 210);
    send(12'd500, 12'd3000);
    idle(1);
    chk("trk_rej_out_new", data_out, {12'd490, 12'd2790});

    // mode swap: ch0 back to fixed, ch1 auto keeping its last programmed value
    bsl_mode = 2'b10;
    bsl_val  = {8'd10, 8'd50};
    idle(1);
    chk("mode_swap_bsl", bsl_cur, {8'd10, 8'd50});

    // saturation on ch1
    for (int i = 1; i <= 16; i++) begin
      send(12'd400, 12'd100);
      if (i == 2) chk("sat_first_data", data_out, {12'd390, 12'd50});
    end
    idle(2);
    chk("sat_bsl", bsl_cur, {8'd255, 8'd50});

    // freeze: no accumulation, subtraction continues
    freeze = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(12'd100, 12'd100);
      if (i == 2) chk("frz_data", data_out, {12'd0, 12'd50});
    end
    idle(2);
    chk("frz_bsl_held", bsl_cur[15:8], 255);
    chk("frz_underflow", underflow, 2'b11);
    freeze = 1'b0;
    for (int i = 1; i <= 15; i++) send(12'd100, 12'd100);
    idle(2);
    chk("frz_cnt_held", bsl_cur[15:8], 255);
    send(12'd100, 12'd100);
    idle(2);
    chk("frz_then_update", bsl_cur[15:8], 100);

    // reset mid-window on ch0
    bsl_mode = 2'b01;
    bsl_val  = {8'd100, 8'd50};
    for (int i = 1; i <= 7; i++) send(12'd200, 12'd300);
    idle(1);
    chk("prerst_out_valid", out_valid, 1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_data_out", data_out, 0);
    chk("arst_bsl_cur", bsl_cur, 0);
    chk("arst_underflow", underflow, 0);
    tick();
    rst_b = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      send(12'd200, 12'd120);
      if (i == 1) chk("post_rst_lat_k1", out_valid, 0);
      if (i == 2) chk("post_rst_first_ov", out_valid, 1);
      if (i == 2) chk("post_rst_first_data", data_out, {12'd100, 12'd120});
    end
    idle(2);
    chk("post_rst_no_early_update", bsl_cur[7:0], 0);
    send(12'd200, 12'd120);
    idle(2);
    chk("post_rst_update", bsl_cur[7:0], 120);

    // clear wins over same-cycle set; set right after clear is kept
    send(12'd50, 12'd120);
    clr_flags = 1'b1;
    send(12'd50, 12'd120);
    chk("clr_wins_flag", underflow, 2'b00);
    chk("clr_wins_data", data_out[23:12], 0);
    clr_flags = 1'b0;
    idle(1);
    chk("set_after_clr", underflow, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldtu_bsl_tracker.md
# ldtu_bsl_tracker

Parametrised multi-channel baseline subtraction with optional automatic baseline tracking, on the single LiTe-DTU clock.
- Each channel's ADC sample is right-shifted, then reduced by either a programmed baseline or a baseline estimated on-chip from quiet samples.
- Underflow is clamped to zero and flagged.
- Sits between ADC input capture and the gain-selection / compression stage; replaces the per-gain fixed-baseline subtractors.

## Interface
Parameters:
- NCH, 2, number of channels
- DW, 12, sample width
- BW, 8, baseline width (BW ≤ DW)
- LOG2_WIN, 4, log2 of auto-baseline averaging window (window = 16 samples)

Ports:
- CLK  input  1  LiTe-DTU clock, all logic on rising edge
- rst_b  input  1  asynchronous, active-low reset
- in_valid  input  1  data_in holds a new sample set (all channels)
- data_in  input  NCH*DW  raw samples; channel c at [c*DW +: DW]
- shift  input  NCH*2  per-channel right shift 0..3
- bsl_mode  input  NCH  per channel: 0 = fixed, 1 = auto
- bsl_val  input  NCH*BW  programmed baseline (fixed mode)
- auto_thr  input  DW  acceptance threshold above current baseline (shared by all channels)
- freeze  input  1  hold all auto-baseline accumulators and counters
- clr_flags  input  1  clear sticky underflow flags
- out_valid  output  1  data_out valid
- data_out  output  NCH*DW  baseline-subtracted samples
- bsl_cur  output  NCH*BW  baseline currently applied per channel
- underflow  output  NCH  sticky: a clamp to zero occurred

## Operation
Pipeline stage S1 (on in_valid):
- d1[c] <= data_in[c] >> shift[c].
- v1 <= in_valid.

Pipeline stage S2 (on v1):
- diff = d1 − bsl_cur, computed in DW+1 bits.
- Negative diff: data_out = 0 and underflow[c] set.
- Otherwise: data_out = diff[DW-1:0].
- out_valid <= v1.
- When v1 = 0, data_out holds its value.

Fixed mode:
- bsl_cur[c] <= bsl_val[c] every cycle.
- Channel FSM forced to INIT; accumulator and counter cleared.

Auto mode, per-channel FSM:
- INIT:
  - On each v1 (and !freeze), every sample is accepted.
  - acc += d1; cnt += 1.
  - When the 2^LOG2_WIN-th sample is accepted, go to UPDATE.
- TRACK:
  - On v1 (and !freeze), a sample is accepted only if d1 ≤ bsl_cur + auto_thr, compared in DW+1 bits.
  - Accepted samples accumulate as in INIT. Rejected samples change nothing.
  - Window full → UPDATE.
- UPDATE (one cycle):
  - avg = acc >> LOG2_WIN.
  - bsl_cur <= avg saturated to 2^BW−1.
  - acc, cnt <= 0; go to TRACK.
  - An S2 sample arriving in this cycle is not accumulated; it is subtracted with the old bsl_cur.
- Widths: acc is DW+LOG2_WIN bits and never overflows; cnt is LOG2_WIN+1 bits.
- Mode change 0→1: FSM starts in INIT with bsl_cur keeping the last programmed value.
- Mode change 1→0: bsl_cur takes bsl_val on the next edge.

freeze:
- Suppresses accumulation and the window-full transition.
- Subtraction continues with the held bsl_cur.

Flags:
- clr_flags has priority over a same-cycle set (clear wins).
- A set that happens in the cycle after clr_flags deasserts is kept.

## Timing
- Latency: in_valid at edge k → out_valid and data_out at edge k+2. Throughput one sample set per cycle.
- bsl_cur change from UPDATE at edge u is applied to the S2 subtraction at edge u+1 onward.
- Fixed-mode bsl_val change at edge k: bsl_cur updates at edge k+1, applied from edge k+2.
- Reset (asynchronous, any time, including mid-window):
  - data_out = 0, out_valid = 0, bsl_cur = 0, underflow = 0.
  - All FSMs INIT; acc and cnt = 0; S1 registers = 0.
- After rst_b release, the first out_valid comes 2 edges after the first in_valid.

## Structure
- Package ldtu_bsl_pkg holds:
  - channel FSM state enum {INIT, TRACK, UPDATE}
  - mode constants BSL_FIXED = 1'b0, BSL_AUTO = 1'b1
  - default parameter values
- Sub-module ldtu_bsl_chan, instantiated NCH times by generate, contains one channel's S1/S2 data path, accumulator, counter and FSM.
- The top level handles only the shared valid pipeline, slicing and flag clearing.

## Test plan
- Fixed: NCH=2, bsl_val = {8'd50, 8'd100}, shift=0, data = {12'd1000, 12'd80} → data_out = {950, 0}, 2 cycles later; underflow[0]=1, underflow[1]=0.
- Shift: shift[c]=2, data_in=12'd4095, bsl_val=8'd23 → data_out = 1023−23 = 1000.
- Auto INIT: mode=1, 16 valid samples of 12'd200 → UPDATE sets bsl_cur = 200; sample 17 = 12'd260 → data_out = 60.
- Auto TRACK rejection: baseline 200, auto_thr = 20, alternate samples 210 / 3000 for 32 inputs → only the sixteen 210s accepted, bsl_cur → 210; the 3000s output 2790 / 2800.
- Saturation: auto mode, 16 samples of 12'd400, BW=8 → bsl_cur = 255; freeze held for 16 further samples → bsl_cur unchanged, cnt unchanged.
- Reset mid-window: assert rst_b=0 after 7 accepted samples → all outputs 0 immediately (asynchronous); after release, 16 fresh samples are needed before the first UPDATE; clr_flags together with an underflow event → flag stays 0.
